// File: rtl/seg7_monitor.sv
// seg7_monitor: watches a single-digit 7-segment display, debounces the
// segment pattern, decodes it back to hex and classifies each accepted
// change as up-step, down-step or illegal jump.
// Optional feature macro: SEG7_DP_CHECK_EN (decimal point joins the filter
// and any accepted pattern with the point lit is flagged as illegal).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | display active, no digit decoded yet (no direction history)
// S_HOLD  | display active, digit holds the last accepted value
// S_BLANK | DS1 high, display blanked; filter held clear
module seg7_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DS1,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    input  logic             e,
    input  logic             f,
    input  logic             g,
    input  logic             h,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             new_digit,
    output logic             dir_up,
    output logic             dir_down,
    output logic             step_err,
    output logic             bad_pattern,
    output logic [CNT_W-1:0] step_count
);

`ifdef SEG7_DP_CHECK_EN
    localparam int SYNC_W = 9;
`else
    localparam int SYNC_W = 8;
`endif
    localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] STAB_PRE = 8'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_BLANK} state_t;

    logic [SYNC_W-1:0] w_pins, r_sync1, r_sync2;
    logic              w_ds1;
    logic [7:0]        w_seg, r_cur_pat, r_stab;
    logic              w_accept, w_dec_ok;
    logic [3:0]        w_dec_val, w_digit_inc, w_digit_dec;

    state_t            r_state, w_state_nxt;
    logic [3:0]        r_digit, w_digit_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_new, w_new_nxt;
    logic              r_up, w_up_nxt;
    logic              r_down, w_down_nxt;
    logic              r_err, w_err_nxt;
    logic              r_bad, w_bad_nxt;
    logic [CNT_W-1:0]  r_count, w_count_nxt;

`ifdef SEG7_DP_CHECK_EN
    assign w_pins = {DS1, h, a, b, c, d, e, f, g};
    assign w_seg  = r_sync2[7:0];
`else
    logic w_unused_h;
    assign w_unused_h = h;
    assign w_pins = {DS1, a, b, c, d, e, f, g};
    assign w_seg  = {1'b0, r_sync2[6:0]};
`endif
    assign w_ds1 = r_sync2[SYNC_W-1];

    // Two-flop synchronizer for all pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_pins;
            r_sync2 <= r_sync1;
        end
    end

    // Stability filter; stab saturates so each stable pattern is accepted once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur_pat <= '0;
            r_stab    <= '0;
        end else if (w_ds1) begin
            r_cur_pat <= '0;
            r_stab    <= '0;
        end else if (w_seg != r_cur_pat) begin
            r_cur_pat <= w_seg;
            r_stab    <= '0;
        end else if (r_stab < STAB_MAX) begin
            r_stab <= r_stab + 8'd1;
        end
    end

    // Accept fires in the cycle stab steps from STABLE_CYCLES-2 to -1.
    assign w_accept = !w_ds1 && (w_seg == r_cur_pat) && (r_stab == STAB_PRE);

    // Glyph decode, bit6=a .. bit0=g; a lit decimal point is illegal when checked.
    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_val = 4'h0;
        case (w_seg[6:0])
            7'h7E: w_dec_val = 4'h0;
            7'h30: w_dec_val = 4'h1;
            7'h6D: w_dec_val = 4'h2;
            7'h79: w_dec_val = 4'h3;
            7'h33: w_dec_val = 4'h4;
            7'h5B: w_dec_val = 4'h5;
            7'h5F: w_dec_val = 4'h6;
            7'h70: w_dec_val = 4'h7;
            7'h7F: w_dec_val = 4'h8;
            7'h7B: w_dec_val = 4'h9;
            7'h77: w_dec_val = 4'hA;
            7'h1F: w_dec_val = 4'hB;
            7'h4E: w_dec_val = 4'hC;
            7'h3D: w_dec_val = 4'hD;
            7'h4F: w_dec_val = 4'hE;
            7'h47: w_dec_val = 4'hF;
            default: w_dec_ok = 1'b0;
        endcase
        if (w_seg[7]) w_dec_ok = 1'b0;
    end

    assign w_digit_inc = r_digit + 4'd1;
    assign w_digit_dec = r_digit - 4'd1;

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_valid_nxt = r_valid;
        w_new_nxt   = 1'b0;
        w_up_nxt    = 1'b0;
        w_down_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_bad_nxt   = r_bad;
        w_count_nxt = r_count;
        if (w_ds1) begin
            w_state_nxt = S_BLANK;
            w_valid_nxt = 1'b0;
            w_bad_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_BLANK: w_state_nxt = S_EMPTY;
                S_EMPTY, S_HOLD: begin
                    if (w_accept) begin
                        if (!w_dec_ok) begin
                            w_bad_nxt = 1'b1;
                        end else begin
                            w_bad_nxt = 1'b0;
                            if (r_state == S_EMPTY) begin
                                w_digit_nxt = w_dec_val;
                                w_valid_nxt = 1'b1;
                                w_new_nxt   = 1'b1;
                                w_state_nxt = S_HOLD;
                            end else if (w_dec_val != r_digit) begin
                                w_digit_nxt = w_dec_val;
                                w_new_nxt   = 1'b1;
                                w_up_nxt    = (w_dec_val == w_digit_inc);
                                w_down_nxt  = (w_dec_val == w_digit_dec);
                                w_err_nxt   = (w_dec_val != w_digit_inc) &&
                                              (w_dec_val != w_digit_dec);
                                if (!(&r_count)) w_count_nxt = r_count + CNT_W'(1);
                            end
                        end
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_EMPTY;
            r_digit <= '0;
            r_valid <= 1'b0;
            r_new   <= 1'b0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_err   <= 1'b0;
            r_bad   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_digit <= w_digit_nxt;
            r_valid <= w_valid_nxt;
            r_new   <= w_new_nxt;
            r_up    <= w_up_nxt;
            r_down  <= w_down_nxt;
            r_err   <= w_err_nxt;
            r_bad   <= w_bad_nxt;
            r_count <= w_count_nxt;
        end
    end

    assign digit       = r_digit;
    assign digit_valid = r_valid;
    assign new_digit   = r_new;
    assign dir_up      = r_up;
    assign dir_down    = r_down;
    assign step_err    = r_err;
    assign bad_pattern = r_bad;
    assign step_count  = r_count;

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed bench for seg7_monitor. A narrow step counter (CNT_W=3) makes
// saturation reachable within the sequence.
module tb_seg7_monitor;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          DS1 = 1'b0;
    logic          a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic          e = 1'b0, f = 1'b0, g = 1'b0, h = 1'b0;
    logic [3:0]    digit;
    logic          digit_valid, new_digit, dir_up, dir_down, step_err, bad_pattern;
    logic [CW-1:0] step_count;

    int n_total = 0;
    int n_bad   = 0;
    int n_new, n_up, n_dn, n_err, first_new;

    seg7_monitor #(.STABLE_CYCLES(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .DS1(DS1),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .digit(digit), .digit_valid(digit_valid), .new_digit(new_digit),
        .dir_up(dir_up), .dir_down(dir_down), .step_err(step_err),
        .bad_pattern(bad_pattern), .step_count(step_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a pattern for n clocks, sampling 1ns after each edge.
    task automatic drive(input logic [6:0] pat, input logic hv, input int n);
        {a, b, c, d, e, f, g} = pat;
        h = hv;
        n_new = 0; n_up = 0; n_dn = 0; n_err = 0; first_new = -1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk); #1;
            if (new_digit) begin
                n_new++;
                if (first_new < 0) first_new = i;
            end
            if (dir_up)   n_up++;
            if (dir_down) n_dn++;
            if (step_err) n_err++;
        end
    endtask

    task automatic chk_step(input string tag, input int e_new, input int e_up,
                            input int e_dn, input int e_err, input logic [3:0] e_dig,
                            input logic [CW-1:0] e_cnt);
        chk({tag, "_new"},   n_new, e_new);
        chk({tag, "_up"},    n_up, e_up);
        chk({tag, "_down"},  n_dn, e_dn);
        chk({tag, "_err"},   n_err, e_err);
        chk({tag, "_digit"}, digit, e_dig);
        chk({tag, "_count"}, step_count, e_cnt);
    endtask

    initial begin
        {a, b, c, d, e, f, g} = 7'h7E;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digit", digit, 0);
        chk("rst_valid", digit_valid, 0);
        chk("rst_new", new_digit, 0);
        chk("rst_bad", bad_pattern, 0);
        chk("rst_count", step_count, 0);
        reset = 1'b1;

        drive(7'h7E, 1'b0, 10);
        chk("first_latency", first_new, 6);
        chk_step("first", 1, 0, 0, 0, 4'h0, 0);
        chk("first_valid", digit_valid, 1);
        chk("first_bad", bad_pattern, 0);

        drive(7'h30, 1'b0, 10);
        chk("up1_latency", first_new, 6);
        chk_step("up1", 1, 1, 0, 0, 4'h1, 1);
        drive(7'h6D, 1'b0, 10);
        chk_step("up2", 1, 1, 0, 0, 4'h2, 2);

        drive(7'h5B, 1'b0, 10);
        chk_step("jump", 1, 0, 0, 1, 4'h5, 3);

        drive(7'h5F, 1'b0, 3);
        chk("glitch_a_new", n_new, 0);
        drive(7'h5B, 1'b0, 10);
        chk_step("glitch", 0, 0, 0, 0, 4'h5, 3);
        chk("glitch_bad", bad_pattern, 0);

        drive(7'h01, 1'b0, 10);
        chk_step("illegal", 0, 0, 0, 0, 4'h5, 3);
        chk("illegal_bad", bad_pattern, 1);
        chk("illegal_valid", digit_valid, 1);

        drive(7'h5B, 1'b0, 10);
        chk_step("same", 0, 0, 0, 0, 4'h5, 3);
        chk("same_bad", bad_pattern, 0);

        drive(7'h01, 1'b0, 10);
        chk("blank_pre_bad", bad_pattern, 1);
        DS1 = 1'b1;
        drive(7'h5B, 1'b0, 4);
        chk_step("blank", 0, 0, 0, 0, 4'h5, 3);
        chk("blank_valid", digit_valid, 0);
        chk("blank_bad", bad_pattern, 0);

        DS1 = 1'b0;
        drive(7'h33, 1'b0, 10);
        chk_step("unblank", 1, 0, 0, 0, 4'h4, 3);
        chk("unblank_valid", digit_valid, 1);

        drive(7'h7E, 1'b0, 10);
        chk_step("jump0", 1, 0, 0, 1, 4'h0, 4);
        drive(7'h47, 1'b0, 10);
        chk_step("wrap_down", 1, 0, 1, 0, 4'hF, 5);
        drive(7'h7E, 1'b0, 10);
        chk_step("wrap_up", 1, 1, 0, 0, 4'h0, 6);

        drive(7'h7E, 1'b1, 10);
`ifdef SEG7_DP_CHECK_EN
        chk("dp_bad", bad_pattern, 1);
`else
        chk("dp_bad", bad_pattern, 0);
`endif
        chk_step("dp", 0, 0, 0, 0, 4'h0, 6);

        drive(7'h30, 1'b0, 10);
        chk_step("sat_in", 1, 1, 0, 0, 4'h1, 7);
        chk("sat_in_bad", bad_pattern, 0);
        drive(7'h6D, 1'b0, 10);
        chk_step("sat_hold", 1, 1, 0, 0, 4'h2, 7);

        drive(7'h47, 1'b0, 6);
        chk("midpulse_new", new_digit, 1);
        chk("midpulse_err", step_err, 1);
        reset = 1'b0;
        #1;
        chk("async_new", new_digit, 0);
        chk("async_err", step_err, 0);
        chk("async_digit", digit, 0);
        chk("async_count", step_count, 0);
        chk("async_valid", digit_valid, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;

        drive(7'h30, 1'b0, 10);
        chk("resume_latency", first_new, 6);
        chk_step("resume", 1, 0, 0, 0, 4'h1, 0);
        chk("resume_valid", digit_valid, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_monitor.md
Name: seg7_monitor

Overview:
- Receive-side counterpart of the team's hex counter / 7-segment driver.
- Watches the segment pins {a..h} and the digit-enable DS1 of a single-digit display.
- Debounces the pattern, decodes it back to a 4-bit hex value, and classifies each accepted change as up-step, down-step or illegal jump.
- Used as an on-board self-check of display counters and as a bench monitor.

Parameters:
STABLE_CYCLES, 4, clocks a synchronized pattern must stay unchanged before acceptance; legal range 2..255
CNT_W, 16, width of the saturating step counter

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-low; clears all state
DS1  input  1  digit enable, 0 = display active, 1 = blanked
a,b,c,d,e,f,g  input  1 each  segment lines, active-high
h  input  1  decimal point, active-high
digit  output  4  last accepted hex value
digit_valid  output  1  high while a decoded digit is held and the display is active
new_digit  output  1  one-cycle pulse when digit is loaded with a changed or first value
dir_up  output  1  one-cycle pulse: new value = previous+1 mod 16
dir_down  output  1  one-cycle pulse: new value = previous-1 mod 16
step_err  output  1  one-cycle pulse: valid new value not adjacent to previous
bad_pattern  output  1  level: last accepted pattern is not a legal glyph
step_count  output  CNT_W  number of accepted changes while in HOLD, saturating

Behaviour:
- Reset values: all outputs 0; FSM = EMPTY.
- Synchronizer: {DS1,a..h} pass through two flops. All logic below uses the synchronized copies.
- Filter (segment view = {a..g}, plus h only when the macro is on):
  - If the sample differs from cur_pat: cur_pat <= sample, stab <= 0.
  - Else, if stab < STABLE_CYCLES-1: stab increments.
  - An accept event fires exactly once, in the cycle stab becomes STABLE_CYCLES-1.
  - A glitch shorter than STABLE_CYCLES restarts the filter and produces no event.
- Decode, bit6=a .. bit0=g:
  - 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7
  - 7F=8, 7B=9, 77=A, 1F=b, 4E=C, 3D=d, 4F=E, 47=F
  - Any other pattern is invalid, including 00 (all segments off).
- Outputs are registered. A clean pin change shows on new_digit exactly STABLE_CYCLES+2 edges after the first edge that samples it (default 6).
- FSM states: EMPTY, HOLD, BLANK.
  - Any state, synchronized DS1=1: go to BLANK. Filter cleared, digit_valid=0, bad_pattern=0, digit holds its value, no pulses.
  - BLANK, synchronized DS1=0: go to EMPTY. Direction history is dropped.
  - EMPTY, valid accept: load digit, digit_valid=1, new_digit pulse, go to HOLD. No dir/err pulse; step_count unchanged.
  - HOLD, valid accept with value equal to digit: only bad_pattern is cleared; no pulses.
  - HOLD, valid accept with a different value: load digit, pulse new_digit plus exactly one of dir_up / dir_down / step_err; step_count+1.
  - Invalid accept (EMPTY or HOLD): bad_pattern=1; digit, digit_valid and state are unchanged.
  - Any valid accept clears bad_pattern.
- Wrap-around: F->0 is dir_up; 0->F is dir_down.
- step_count: sticks at all-ones; cleared only by reset, not by BLANK.
- Reset mid-filter or mid-pulse: everything clears immediately (asynchronous). Resumes in EMPTY after reset release.

Optional Feature:
SEG7_DP_CHECK_EN:
- Defined: h joins the filter compare, and any accepted pattern with h=1 is invalid (sets bad_pattern).
- Undefined: h is ignored entirely; a toggling h neither restarts the filter nor affects decode.

Test Plan:
- Reset, then hold DS1=0 with pattern 7E for 10 clocks -> new_digit pulse at edge 6, digit=0, digit_valid=1, no dir pulse, step_count=0.
- From digit=0, drive 30 then 6D, each held 10 clocks -> two dir_up pulses, digit=2, step_count=2.
- From digit=0, drive 47 -> dir_down pulse (wrap), digit=F. Then drive 7E -> dir_up pulse (wrap), digit=0.
- From digit=2, drive 5B for 10 clocks -> step_err pulse, digit=5. Drive 5F for only 3 clocks, then back to 5B -> no pulses, digit stays 5.
- From digit=5, drive 01 -> bad_pattern=1, digit=5. Drive 5B -> bad_pattern=0, no pulse. Drive DS1=1 -> digit_valid=0. Release DS1, drive 33 -> new_digit only, no dir pulse, step_count unchanged.
- With SEG7_DP_CHECK_EN defined, drive 7E with h=1 -> bad_pattern=1. Undefined, same stimulus -> digit=0, bad_pattern=0.
